// File: rtl/avalon_burst_arbiter.sv
// Round-robin Avalon burst arbiter: grants one requester at a time and holds the grant for a whole burst.
// Optional stall watchdog is built when AVALON_ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no grant, arbitrate among current requests
// CMD    | grant issued, waiting for the command to be accepted by the slave
// WRITE  | counting accepted write beats of the granted burst
// READ   | counting ReadDataValid beats of the granted burst
module avalon_burst_arbiter #(
    parameter int NUM_INPUTS     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_n,
    input  logic [NUM_INPUTS-1:0]             i_AV_Read,
    input  logic [NUM_INPUTS-1:0]             i_AV_Write,
    input  logic [8*NUM_INPUTS-1:0]           i_AV_BurstCount,
    input  logic                              i_AVOut_WaitRequest,
    input  logic                              i_AVOut_ReadDataValid,
    output logic [$clog2(NUM_INPUTS+1)-1:0]   o_MuxSel,
    output logic [NUM_INPUTS-1:0]             o_Grant,
    output logic                              o_Busy,
    output logic                              o_Timeout
);

    localparam int SW = $clog2(NUM_INPUTS+1);

    if (NUM_INPUTS < 1 || NUM_INPUTS > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("avalon_burst_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          ptr_q, ptr_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [NUM_INPUTS-1:0]  grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   tout_q, tout_d;
    logic [7:0]             burst_q, burst_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [NUM_INPUTS-1:0]  req_vec;
    logic [SW-1:0]          winner;
    logic [SW-1:0]          next_ptr;
    logic                   gnt_rd, gnt_wr;
    logic [7:0]             gnt_burst, gnt_eff;
    logic                   progress;
    logic                   abort;

    // Search starts at the pointer and wraps; the lowest offset with a request wins.
    function automatic logic [SW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                              input logic [SW-1:0] ptr);
        logic [SW-1:0] pick;
        int            idx;
        pick = '0;
        for (int off = NUM_INPUTS-1; off >= 0; off--) begin
            idx = int'(ptr) - 1 + off;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (req[idx]) pick = SW'(idx + 1);
        end
        return pick;
    endfunction

    assign req_vec  = i_AV_Read | i_AV_Write;
    assign winner   = rr_pick(req_vec, ptr_q);
    assign next_ptr = (sel_q == SW'(NUM_INPUTS)) ? SW'(1) : sel_q + SW'(1);
    assign gnt_eff  = (gnt_burst == 8'd0) ? 8'd1 : gnt_burst;

    always_comb begin
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_burst = 8'd0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            if (sel_q == SW'(k)) begin
                gnt_rd    = i_AV_Read[k-1];
                gnt_wr    = i_AV_Write[k-1];
                gnt_burst = i_AV_BurstCount[8*(k-1) +: 8];
            end
        end
    end

    assign progress = ((state_q == S_CMD)   && (gnt_wr || gnt_rd) && !i_AVOut_WaitRequest) ||
                      ((state_q == S_WRITE) && gnt_wr && !i_AVOut_WaitRequest) ||
                      ((state_q == S_READ)  && i_AVOut_ReadDataValid);

`ifdef AVALON_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    logic [TW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        abort   = 1'b0;
        if (state_q == S_IDLE || progress) begin
            stall_d = '0;
        end else begin
            stall_d = stall_q + TW'(1);
            if (stall_d == TW'(TIMEOUT_CYCLES)) abort = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= SW'(1);
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            burst_q <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        logic done;
        state_d = state_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_vec) state_d = S_CMD;
            end
            S_CMD: begin
                if (gnt_wr && !i_AVOut_WaitRequest) begin
                    burst_d = gnt_eff;
                    cnt_d   = 8'd1;
                    if (gnt_eff == 8'd1) done = 1'b1;
                    else                 state_d = S_WRITE;
                end else if (gnt_rd && !i_AVOut_WaitRequest) begin
                    burst_d = gnt_eff;
                    cnt_d   = i_AVOut_ReadDataValid ? 8'd1 : 8'd0;
                    if (i_AVOut_ReadDataValid && gnt_eff == 8'd1) done = 1'b1;
                    else                                          state_d = S_READ;
                end else if (!gnt_rd && !gnt_wr) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (gnt_wr && !i_AVOut_WaitRequest) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == burst_q) done = 1'b1;
                end
            end
            S_READ: begin
                if (i_AVOut_ReadDataValid) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == burst_q) done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done || abort) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
        end
    end

    always_comb begin
        if (state_q == S_IDLE)
            sel_d = (state_d == S_CMD) ? winner : '0;
        else if (state_d == S_IDLE)
            sel_d = '0;
        else
            sel_d = sel_q;
        grant_d = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            grant_d[k-1] = (sel_d == SW'(k));
        end
        busy_d = (state_d != S_IDLE);
        tout_d = abort;
    end

    assign o_MuxSel  = sel_q;
    assign o_Grant   = grant_q;
    assign o_Busy    = busy_q;
    assign o_Timeout = tout_q;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed bench for avalon_burst_arbiter with three requesters and a 16-cycle watchdog limit.
module tb_avalon_burst_arbiter;

    localparam int N  = 3;
    localparam int SW = $clog2(N+1);

    logic            clk_sys = 1'b0;
    logic            rst_n;
    logic [N-1:0]    av_read, av_write;
    logic [8*N-1:0]  av_bc;
    logic            wait_req, rdv;
    logic [SW-1:0]   mux_sel;
    logic [N-1:0]    grant;
    logic            busy, tout;

    int n_checks = 0;
    int n_errors = 0;

    avalon_burst_arbiter #(.NUM_INPUTS(N), .TIMEOUT_CYCLES(16)) u_dut (
        .i_Clk                 (clk_sys),
        .i_Rst_n               (rst_n),
        .i_AV_Read             (av_read),
        .i_AV_Write            (av_write),
        .i_AV_BurstCount       (av_bc),
        .i_AVOut_WaitRequest   (wait_req),
        .i_AVOut_ReadDataValid (rdv),
        .o_MuxSel              (mux_sel),
        .o_Grant               (grant),
        .o_Busy                (busy),
        .o_Timeout             (tout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_bc(input int k, input logic [7:0] v);
        av_bc[8*(k-1) +: 8] = v;
    endtask

    int exp_rr [8]   = '{2, 0, 1, 0, 2, 0, 1, 0};
    logic wr_wait [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic rd_pat [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};

    initial begin
        int beats;
        rst_n    = 1'b0;
        av_read  = '0;
        av_write = '0;
        av_bc    = '0;
        wait_req = 1'b0;
        rdv      = 1'b0;
        step();
        step();
        check("rst_sel",   mux_sel, 0);
        check("rst_grant", grant,   0);
        check("rst_busy",  busy,    0);
        check("rst_tout",  tout,    0);

        // single-beat write from requester 1
        rst_n    = 1'b1;
        av_write = 3'b001;
        set_bc(1, 8'd1);
        step();
        check("w1_sel",   mux_sel, 1);
        check("w1_grant", grant,   3'b001);
        check("w1_busy",  busy,    1);
        step();
        av_write = '0;
        check("w1_done_sel",  mux_sel, 0);
        check("w1_done_busy", busy,    0);

        // two requesters with continuous single-beat writes; pointer is at 2
        av_write = 3'b011;
        set_bc(2, 8'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_sel", mux_sel, exp_rr[i]);
        end
        av_write = '0;

        // 4-beat write from requester 2 with waitrequest mid-burst; pointer is at 2
        av_write = 3'b010;
        set_bc(2, 8'd4);
        for (int i = 0; i < 8; i++) begin
            wait_req = wr_wait[i];
            step();
            check("b4_sel", mux_sel, (i == 7) ? 0 : 2);
        end
        av_write = '0;
        wait_req = 1'b0;
        check("b4_grant", grant, 0);

        // 8-beat read from requester 1, pointer at 3; valid in IDLE must be ignored
        av_read = 3'b001;
        set_bc(1, 8'd8);
        rdv = 1'b1;
        step();
        check("rd_sel_cmd", mux_sel, 1);
        rdv = 1'b0;
        step();
        av_read = '0;
        check("rd_sel_acc", mux_sel, 1);
        beats = 0;
        for (int i = 0; i < 12; i++) begin
            rdv = rd_pat[i];
            step();
            if (rd_pat[i]) beats++;
            check("rd_sel", mux_sel, (beats < 8) ? 1 : 0);
        end
        rdv = 1'b0;

        // request withdrawn in CMD: pointer stays at 2, then wrap 3 -> 1
        wait_req = 1'b1;
        av_write = 3'b010;
        step();
        check("drop_sel_cmd", mux_sel, 2);
        av_write = '0;
        step();
        check("drop_sel_idle", mux_sel, 0);
        wait_req = 1'b0;
        av_write = 3'b110;
        set_bc(2, 8'd1);
        set_bc(3, 8'd1);
        step();
        check("drop_ptr_kept", mux_sel, 2);
        step();
        check("drop_done", mux_sel, 0);
        step();
        check("wrap_sel3",   mux_sel, 3);
        check("wrap_grant3", grant,   3'b100);
        step();
        av_write = '0;
        check("wrap_done", mux_sel, 0);

        // burst count 0 behaves as a single beat; pointer is at 1
        av_write = 3'b001;
        set_bc(1, 8'd0);
        step();
        check("bc0_sel", mux_sel, 1);
        step();
        av_write = '0;
        check("bc0_done", mux_sel, 0);

        // stuck waitrequest on requester 3; pointer is at 2
        wait_req = 1'b1;
        av_write = 3'b100;
        set_bc(3, 8'd1);
        step();
        check("stall_sel", mux_sel, 3);
`ifdef AVALON_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            step();
            check("to_hold_sel",  mux_sel, 3);
            check("to_hold_tout", tout,    0);
        end
        av_write = 3'b101;
        set_bc(1, 8'd1);
        step();
        check("to_pulse",     tout,    1);
        check("to_sel",       mux_sel, 0);
        check("to_busy",      busy,    0);
        step();
        check("to_pulse_end", tout,    0);
        check("to_next",      mux_sel, 1);
        wait_req = 1'b0;
        step();
        av_write = '0;
        check("to_next_done", mux_sel, 0);
`else
        for (int i = 1; i < 24; i++) begin
            step();
            check("hold_sel",  mux_sel, 3);
            check("hold_tout", tout,    0);
        end
        av_write = '0;
        wait_req = 1'b0;
        step();
        check("hold_release", mux_sel, 0);
`endif

        // reset during beat 2 of a 4-beat write
        av_write = 3'b001;
        set_bc(1, 8'd4);
        step();
        check("rb_sel", mux_sel, 1);
        step();
        rst_n = 1'b0;
        step();
        check("rb_sel0",   mux_sel, 0);
        check("rb_grant0", grant,   0);
        check("rb_busy0",  busy,    0);
        check("rb_tout0",  tout,    0);
        av_write = 3'b101;
        set_bc(1, 8'd1);
        set_bc(3, 8'd1);
        rst_n = 1'b1;
        step();
        check("rb_ptr_reset", mux_sel, 1);
        check("rb_grant1",    grant,   3'b001);
        av_write = '0;
        step();
        step();
        check("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avalon_burst_arbiter.md
AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of Avalon requesters, range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall limit used only under REQ-031.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_AV_Read, input, NUM_INPUTS bits: requester read strobes, bit k-1 = requester k.
REQ-006 SHALL have port i_AV_Write, input, NUM_INPUTS bits: requester write strobes.
REQ-007 SHALL have port i_AV_BurstCount, input, 8*NUM_INPUTS bits: per-requester burst length, slice [8*(k-1) +: 8].
REQ-008 SHALL have port i_AVOut_WaitRequest, input, 1 bit: shared slave waitrequest.
REQ-009 SHALL have port i_AVOut_ReadDataValid, input, 1 bit: shared slave read-beat strobe.
REQ-010 SHALL have port o_MuxSel, output, $clog2(NUM_INPUTS+1) bits: mux select; 0 = terminated/idle input, k = requester k.
REQ-011 SHALL have port o_Grant, output, NUM_INPUTS bits: one-hot grant, bit k-1 set when o_MuxSel = k.
REQ-012 SHALL have port o_Busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port o_Timeout, output, 1 bit: one-cycle abort pulse.

Function
REQ-014 SHALL implement states IDLE, CMD, WRITE, READ; all outputs registered.
REQ-015 Requester k is requesting when i_AV_Read[k-1] | i_AV_Write[k-1].
REQ-016 IDLE: o_MuxSel = 0; if any request, select the winner by round-robin from the priority pointer, load o_MuxSel = winner, and go to CMD; grant is visible the cycle after the request is first sampled.
REQ-017 Round-robin: the pointer SHALL reset to requester 1 and, on each return to IDLE from a completed or aborted grant, SHALL move to the granted index + 1, wrapping NUM_INPUTS -> 1.
REQ-018 CMD: on granted write & !i_AVOut_WaitRequest, latch BurstCount and count one beat; if BurstCount <= 1 go to IDLE, else go to WRITE.
REQ-019 CMD: on granted read & !i_AVOut_WaitRequest, latch BurstCount, clear the beat counter, and go to READ.
REQ-020 CMD: if the granted requester drops both read and write before acceptance, SHALL go to IDLE without moving the pointer.
REQ-021 WRITE: count write & !waitrequest beats; when count reaches the latched BurstCount, go to IDLE.
REQ-022 READ: count i_AVOut_ReadDataValid beats, including a beat in the same cycle as command acceptance; when count reaches the latched BurstCount, go to IDLE.
REQ-023 BurstCount 0 SHALL be treated as 1; the beat counter is 8 bits and reaches 255 without wrap.
REQ-024 o_MuxSel SHALL never change outside IDLE->CMD or ->IDLE transitions; it returns to 0 the cycle after the last beat.
REQ-025 Simultaneous requests SHALL resolve strictly by pointer order; non-granted requests are held off by the mux's terminated input, with no action required here.
REQ-026 ReadDataValid in IDLE, CMD-before-read, or WRITE SHALL be ignored.

Reset
REQ-027 When i_Rst_n = 0 at a clock edge: state = IDLE, o_MuxSel = 0, o_Grant = 0, o_Busy = 0, o_Timeout = 0, pointer = 1, counters = 0.
REQ-028 Reset mid-burst SHALL abandon the burst immediately, with no completion handshake.
REQ-029 The first arbitration SHALL occur on the first edge with i_Rst_n = 1.

Configuration
REQ-030 Macro AVALON_ARB_TIMEOUT_EN selects the watchdog.
REQ-031 With the macro defined: a stall counter clears on entry to CMD and on every accepted beat or ReadDataValid; if it reaches TIMEOUT_CYCLES in CMD, WRITE, or READ, the block SHALL go to IDLE, advance the pointer, and pulse o_Timeout for one cycle.
REQ-032 Without the macro: no counter is built, o_Timeout is tied 0, and grants hold indefinitely.

Verification
REQ-033 Req1 write, BurstCount=1, waitrequest low -> o_MuxSel 0->1 next cycle; back to 0 one cycle after acceptance.
REQ-034 Req1 and Req2 requesting continuously, single beats -> grants alternate 1,2,1,2; IDLE cycle between each.
REQ-035 Req2 write BurstCount=4, waitrequest high 3 cycles mid-burst -> o_MuxSel holds 2 until the 4th accepted beat.
REQ-036 Req1 read BurstCount=8, ReadDataValid beats spaced irregularly -> grant holds until the 8th valid, then o_MuxSel=0.
REQ-037 Reset asserted during beat 2 of a 4-beat write -> next cycle all outputs 0, pointer=1.
REQ-038 With AVALON_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck high -> o_Timeout pulses at stall cycle 16, o_MuxSel=0, and the next grant goes to the following requester.
